// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
// Bus layout is {we, waddr[4:0], wdata[31:0]} on both WB and RF sides.
package rf_wport_arbiter_pkg;

    localparam int WS_TO_RF_BUS_WD = 38;
    localparam int RF_BUS_WD       = 38;
    localparam int LU_RES_WD       = 37;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_wr_t;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } lu_res_t;

    function automatic logic addr_hit(input logic [4:0] rs, input logic [4:0] waddr,
                                      input logic vld);
        return vld && (rs != 5'd0) && (rs == waddr);
    endfunction

endpackage

// File: rtl/rf_wport_arbiter_lu_fifo.sv
// Synchronous LU result buffer; registered outputs only, no bypass from push to head.
// Per-entry valid and waddr are exposed so ID can interlock on pending destinations.
module rf_wport_arbiter_lu_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  lu_res_t               i_push_dat,
    input  logic                  i_pop,
    output lu_res_t               o_head_dat,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH-1:0]      o_ent_vld,
    output logic [DEPTH-1:0][4:0] o_ent_addr
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    lu_res_t          r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;

    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_push;
    logic          w_pop;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_push   = i_push && !o_full;
    assign w_pop    = i_pop && !o_empty;

    assign o_head_dat = r_mem[w_rd_idx];
    assign o_ent_vld  = r_vld;

    always_comb begin
        o_ent_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_ent_addr[i] = r_mem[i].waddr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_vld    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // Push and pop never target the same slot: that would need full and empty at once.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (w_wr_idx == AW'(i)))      r_vld[i] <= 1'b1;
                else if (w_pop && (w_rd_idx == AW'(i)))  r_vld[i] <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset; r_vld qualifies every slot.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_idx] <= i_push_dat;
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the RF write port between WB (fixed priority) and a buffered LU writer,
// with an aging counter that stalls WB once queued LU results have waited MAX_WAIT cycles.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
    output logic                       ws_stall,
    input  logic                       lu_valid,
    output logic                       lu_ready,
    input  logic [4:0]                 lu_waddr,
    input  logic [31:0]                lu_wdata,
    output logic [RF_BUS_WD-1:0]       rf_bus,
    input  logic [4:0]                 id_rs1,
    input  logic [4:0]                 id_rs2,
    output logic                       id_lu_hit
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    rf_wr_t                    w_ws;
    rf_wr_t                    w_rf;
    lu_res_t                   w_push_dat;
    lu_res_t                   w_head;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_force;
    logic                      w_fifo_gnt;
    logic [FIFO_DEPTH-1:0]     w_ent_vld;
    logic [FIFO_DEPTH-1:0][4:0] w_ent_addr;
    logic [CW-1:0]             r_wait_cnt;

    assign w_ws       = rf_wr_t'(ws_to_rf_bus);
    assign w_push_dat = '{waddr: lu_waddr, wdata: lu_wdata};

    assign lu_ready   = !w_full;
    // A zero destination completes the handshake but is never buffered.
    assign w_push     = lu_valid && lu_ready && (lu_waddr != 5'd0) && !reset;
    assign w_force    = (r_wait_cnt >= CW'(MAX_WAIT)) && !w_empty;
    assign w_fifo_gnt = w_force || (!w_ws.we && !w_empty);
    assign w_pop      = w_fifo_gnt && !reset;
    assign ws_stall   = w_force && w_ws.we && !reset;

    always_comb begin
        w_rf = '0;
        if (w_fifo_gnt) begin
            w_rf.we    = 1'b1;
            w_rf.waddr = w_head.waddr;
            w_rf.wdata = w_head.wdata;
        end else if (w_ws.we) begin
            w_rf.we    = (w_ws.waddr != 5'd0);
            w_rf.waddr = w_ws.waddr;
            w_rf.wdata = w_ws.wdata;
        end
        if (reset) w_rf.we = 1'b0;
    end

    assign rf_bus = w_rf;

    always_comb begin
        id_lu_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (addr_hit(id_rs1, w_ent_addr[i], w_ent_vld[i]) ||
                addr_hit(id_rs2, w_ent_addr[i], w_ent_vld[i])) begin
                id_lu_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_empty || w_fifo_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt < CW'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    rf_wport_arbiter_lu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_lu_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_ent_vld  (w_ent_vld),
        .o_ent_addr (w_ent_addr)
    );

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Randomized and directed bench for rf_wport_arbiter against a queue-based reference model.
module tb_rf_wport_arbiter;

    localparam int DEPTH = 2;
    localparam int MAXW  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] ws_to_rf_bus = '0;
    logic        ws_stall;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_waddr = '0;
    logic [31:0] lu_wdata = '0;
    logic [37:0] rf_bus;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic        id_lu_hit;

    int n_chk  = 0;
    int n_fail = 0;

    logic [36:0] mq[$];
    int          lost = 0;
    bit          last_stall = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .MAX_WAIT   (MAXW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ws_to_rf_bus (ws_to_rf_bus),
        .ws_stall     (ws_stall),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_waddr     (lu_waddr),
        .lu_wdata     (lu_wdata),
        .rf_bus       (rf_bus),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_lu_hit    (id_lu_hit)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare, then advance the model.
    task automatic do_cycle(input bit rst, input bit wwe, input logic [4:0] wa,
                            input logic [31:0] wd, input bit lv, input logic [4:0] la,
                            input logic [31:0] ld, input logic [4:0] r1, input logic [4:0] r2);
        bit          empty, frc, fg, rdy, hit;
        logic [37:0] e;
        @(negedge clk);
        reset = rst;
        ws_to_rf_bus = {wwe, wa, wd};
        lu_valid = lv; lu_waddr = la; lu_wdata = ld;
        id_rs1 = r1; id_rs2 = r2;
        #1;
        if (rst) begin
            check_val("rst_we", 64'(rf_bus[37]), 64'd0);
            check_val("rst_stall", 64'(ws_stall), 64'd0);
            mq.delete();
            lost = 0;
            last_stall = 0;
        end else begin
            empty = (mq.size() == 0);
            frc   = (lost >= MAXW) && !empty;
            fg    = frc || (!wwe && !empty);
            rdy   = (mq.size() < DEPTH);
            if (fg)       e = {1'b1, mq[0]};
            else if (wwe) e = {(wa != 5'd0), wa, wd};
            else          e = '0;
            hit = 0;
            foreach (mq[i]) begin
                if (r1 != 0 && mq[i][36:32] == r1) hit = 1;
                if (r2 != 0 && mq[i][36:32] == r2) hit = 1;
            end
            check_val("rf_we", 64'(rf_bus[37]), 64'(e[37]));
            if (e[37]) check_val("rf_addr_dat", 64'(rf_bus[36:0]), 64'(e[36:0]));
            check_val("ws_stall", 64'(ws_stall), 64'(frc && wwe));
            check_val("lu_ready", 64'(lu_ready), 64'(rdy));
            check_val("id_lu_hit", 64'(id_lu_hit), 64'(hit));
            last_stall = frc && wwe;
            if (fg) begin
                void'(mq.pop_front());
                lost = 0;
            end else if (empty) begin
                lost = 0;
            end else if (lost < MAXW) begin
                lost++;
            end
            if (lv && rdy && la != 5'd0) mq.push_back({la, ld});
        end
    endtask

    initial begin
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          wwe;

        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Idle
        for (int i = 0; i < 10; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 5, 9);

        // Single LU push, WB idle
        do_cycle(0, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
        check_val("t2_bus", 64'(rf_bus), 64'({1'b1, 5'd5, 32'hDEAD_BEEF}));
        check_val("t2_hit", 64'(id_lu_hit), 64'd1);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
        check_val("t2_hit_gone", 64'(id_lu_hit), 64'd0);

        // Aging: WB busy, one LU entry
        do_cycle(0, 1, 5'd3, 32'h100, 1, 5'd7, 32'h7777, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            if (!last_stall) begin
                wa = 5'd3; wd = 32'h100 + 32'(k);
            end
            do_cycle(0, 1, wa, wd, 0, 0, 0, 5'd7, 0);
            if (k == 5) begin
                check_val("t3_stall", 64'(ws_stall), 64'd1);
                check_val("t3_addr", 64'(rf_bus[36:32]), 64'd7);
            end
            if (k == 6) check_val("t3_resume", 64'(rf_bus), 64'({1'b1, 5'd3, 32'h105}));
        end

        // Fill with WB busy, LU offering continuously
        for (int k = 0; k < 14; k++)
            do_cycle(0, 1, 5'd4, 32'(k), 1, 5'(10 + k), 32'hA000 + 32'(k), 5'(10 + k), 0);

        // Drain, then push to x0
        for (int k = 0; k < 4; k++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 1, 5'd0, 32'h1234, 0, 0);
        check_val("t5_ready", 64'(lu_ready), 64'd1);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_val("t5_no_we", 64'(rf_bus[37]), 64'd0);

        // Reset with two entries queued and aging at 3
        do_cycle(0, 1, 5'd2, 32'h1, 1, 5'd20, 32'hBAD0, 0, 0);
        do_cycle(0, 1, 5'd2, 32'h2, 1, 5'd21, 32'hBAD1, 0, 0);
        do_cycle(0, 1, 5'd2, 32'h3, 0, 0, 0, 0, 0);
        do_cycle(0, 1, 5'd2, 32'h4, 0, 0, 0, 0, 0);
        do_cycle(1, 1, 5'd2, 32'h5, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 5'd20, 5'd21);
        check_val("t6_ready", 64'(lu_ready), 64'd1);
        check_val("t6_we", 64'(rf_bus[37]), 64'd0);
        check_val("t6_hit", 64'(id_lu_hit), 64'd0);
        for (int k = 0; k < 6; k++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        wwe = 0; wa = 0; wd = 0;
        for (int k = 0; k < 3000; k++) begin
            logic [4:0] r1;
            if (!last_stall) begin
                wwe = ($urandom_range(0, 9) < 7);
                wa  = 5'($urandom_range(0, 31));
                wd  = $urandom;
            end
            r1 = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0][36:32]
                                                              : 5'($urandom_range(0, 31));
            do_cycle(($urandom_range(0, 199) == 0), wwe, wa, wd,
                     ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
                     r1, 5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
